// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock and its code sender.
package lock_pkg;

  localparam int unsigned SYMBOL_W = 3;

  // Symbol that returns the lock to its start state.
  localparam logic [SYMBOL_W-1:0] IDLE_SYM = 3'b000;

  // Unlock code, symbol 0 in the most-significant group.
  localparam logic [3*SYMBOL_W-1:0] LOCK_CODE = 9'b011_111_101;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StGap
  } sender_state_e;

endpackage

// File: rtl/lock_hold_counter.sv
// Loadable down-counter with terminal-count flag; times symbol holds, timeouts and gaps.
// Loading N-1 makes tc_o high on the N-th cycle after the load.
module lock_hold_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Plays a stored code onto the lock's x input and reports pass/fail from its y flag.
// Build option: define LOCK_SENDER_RETRY_EN to enable gap-separated retries up to
// MAX_ATTEMPTS; otherwise a single attempt is made and GAP is never entered.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int unsigned SYMBOL_W     = 3,
  parameter int unsigned CODE_LEN     = 3,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned TIMEOUT      = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [CODE_LEN*SYMBOL_W-1:0]        code,
  input  logic                                y_in,
  output logic [SYMBOL_W-1:0]                 x_out,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                fail,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts
);

  localparam int unsigned CodeW = CODE_LEN * SYMBOL_W;
  localparam int unsigned AttW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned IdxW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned HoldM = HOLD_CYCLES - 1;
  localparam int unsigned ToutM = TIMEOUT - 1;
  localparam int unsigned GapM  = GAP_CYCLES - 1;
  localparam int unsigned Max1  = (HoldM > ToutM) ? HoldM : ToutM;
  localparam int unsigned CntMx = (Max1 > GapM) ? Max1 : GapM;
  localparam int unsigned CntW  = (CntMx < 2) ? 1 : $clog2(CntMx + 1);

  localparam logic [SYMBOL_W-1:0] Idle = SYMBOL_W'(IDLE_SYM);

  // Symbol k of a code, symbol 0 taken from the most-significant group.
  function automatic logic [SYMBOL_W-1:0] sym_at(input logic [CodeW-1:0] c,
                                                 input int unsigned k);
    logic [CodeW-1:0] s;
    s = c << (k * SYMBOL_W);
    return s[CodeW-1 -: SYMBOL_W];
  endfunction

  sender_state_e       state_q;
  logic [CodeW-1:0]    code_q;
  logic [IdxW-1:0]     idx_q;
  logic [SYMBOL_W-1:0] x_q;
  logic                busy_q, done_q, pass_q, fail_q;
  logic [AttW-1:0]     att_q;

  logic                cnt_load;
  logic [CntW-1:0]     cnt_val;
  logic                cnt_tc;
  logic                accept;
  logic                last_sym;

  // A start coinciding with the done pulse is refused.
  assign accept   = (state_q == StIdle) && start && !done_q;
  assign last_sym = (idx_q == IdxW'(CODE_LEN - 1));

  // Reload the shared timer on every phase boundary.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      StIdle: begin
        cnt_load = accept;
        cnt_val  = CntW'(HoldM);
      end
      StSend: begin
        cnt_load = cnt_tc;
        cnt_val  = last_sym ? CntW'(ToutM) : CntW'(HoldM);
      end
`ifdef LOCK_SENDER_RETRY_EN
      StWait: begin
        cnt_load = !y_in && cnt_tc;
        cnt_val  = CntW'(GapM);
      end
      StGap: begin
        cnt_load = cnt_tc;
        cnt_val  = CntW'(HoldM);
      end
`endif
      default: ;
    endcase
  end

  lock_hold_counter #(
    .Width(CntW)
  ) u_hold_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .tc_o      (cnt_tc)
  );

  // Sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= '0;
      idx_q   <= '0;
      x_q     <= Idle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      att_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            code_q  <= code;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            att_q   <= AttW'(1);
            idx_q   <= '0;
            x_q     <= sym_at(code, 0);
            busy_q  <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (cnt_tc) begin
            if (last_sym) begin
              x_q     <= Idle;
              state_q <= StWait;
            end else begin
              idx_q <= idx_q + IdxW'(1);
              x_q   <= sym_at(code_q, int'(idx_q) + 1);
            end
          end
        end
        StWait: begin
          if (y_in) begin
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_tc) begin
`ifdef LOCK_SENDER_RETRY_EN
            if (att_q < AttW'(MAX_ATTEMPTS)) begin
              state_q <= StGap;
            end else begin
              fail_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
`else
            fail_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
`endif
          end
        end
`ifdef LOCK_SENDER_RETRY_EN
        StGap: begin
          if (cnt_tc) begin
            att_q   <= att_q + AttW'(1);
            idx_q   <= '0;
            x_q     <= sym_at(code_q, 0);
            state_q <= StSend;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign x_out    = x_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign attempts = att_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: two instances (hold 1 and hold 3) against an elapsed-time model.
module tb_lock_code_sender;
  import lock_pkg::*;

  localparam int L = 3;
  localparam int T = 4;
  localparam int G = 2;
`ifdef LOCK_SENDER_RETRY_EN
  localparam int MAXA  = 3;
  localparam int DONE2 = 25;
  localparam int DONE3 = 13;
  localparam int PASS3 = 1;
  localparam int ATT3  = 2;
  localparam int X9    = 3;
`else
  localparam int MAXA  = 1;
  localparam int DONE2 = 7;
  localparam int DONE3 = 7;
  localparam int PASS3 = 0;
  localparam int ATT3  = 1;
  localparam int X9    = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [8:0] code;
  logic       y0, y1;
  logic [2:0] x0, x1;
  logic       busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
  logic [1:0] att0, att1;

  always #5 clk = ~clk;

  lock_code_sender #(.HOLD_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .code(code), .y_in(y0), .x_out(x0),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .attempts(att0)
  );

  lock_code_sender #(.HOLD_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .code(code), .y_in(y1), .x_out(x1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .attempts(att1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lock stand-in for instance 0: y rises the cycle after the last three x samples spell
  // LOCK_CODE; in second-match mode the first complete entry is refused.
  logic [8:0] hist_q = '0;
  logic       lock_y_q = 1'b0;
  int         n_match_q = 0;
  logic       lk_second = 1'b0, lk_clr = 1'b0;
  int         ymode = 0;
  logic       yr0 = 1'b0, yr1 = 1'b0;

  always @(posedge clk) begin
    automatic logic [8:0] h = {hist_q[5:0], x0};
    automatic logic       m = (h == LOCK_CODE);
    hist_q   <= h;
    lock_y_q <= m && (!lk_second || n_match_q == 1);
    if (lk_clr) n_match_q <= 0;
    else if (m) n_match_q <= n_match_q + 1;
  end

  assign y0 = (ymode == 2) ? yr0 : lock_y_q;
  assign y1 = yr1;

  // Reference model: time since accept t; attempt a = t / period, position p = t % period.
  logic       m_act [2] = '{1'b0, 1'b0};
  int         m_t   [2] = '{0, 0};
  logic [8:0] m_code[2] = '{9'd0, 9'd0};
  logic       m_done[2] = '{1'b0, 1'b0};
  logic       m_pass[2] = '{1'b0, 1'b0};
  logic       m_fail[2] = '{1'b0, 1'b0};
  int         m_att [2] = '{0, 0};

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int   lh  = L * hold_of(i);
      automatic int   per = lh + T + G;
      automatic int   p   = m_t[i] % per;
      automatic int   a   = m_t[i] / per;
      automatic logic yv  = (i == 0) ? y0 : y1;
      if (reset) begin
        m_act[i] <= 1'b0; m_t[i] <= 0; m_done[i] <= 1'b0;
        m_pass[i] <= 1'b0; m_fail[i] <= 1'b0; m_att[i] <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_act[i]) begin
          if (start && !m_done[i]) begin
            m_act[i] <= 1'b1; m_t[i] <= 0; m_code[i] <= code;
            m_pass[i] <= 1'b0; m_fail[i] <= 1'b0; m_att[i] <= 1;
          end
        end else begin
          m_t[i] <= m_t[i] + 1;
          if (p >= lh && p < lh + T) begin
            if (yv) begin
              m_pass[i] <= 1'b1; m_done[i] <= 1'b1; m_act[i] <= 1'b0;
            end else if (p == lh + T - 1 && a + 1 >= MAXA) begin
              m_fail[i] <= 1'b1; m_done[i] <= 1'b1; m_act[i] <= 1'b0;
            end
          end
          if (p == per - 1) m_att[i] <= a + 2;
        end
      end
    end
  end

  function automatic logic [2:0] exp_x(input int i);
    automatic int         h  = hold_of(i);
    automatic int         lh = L * h;
    automatic int         p  = m_t[i] % (lh + T + G);
    automatic logic [8:0] c  = m_code[i] << ((p / h) * 3);
    if (m_act[i] && p < lh) return c[8:6];
    return 3'b000;
  endfunction

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("x0", 32'(x0), 32'(exp_x(0)));
      check("busy0", 32'(busy0), 32'(m_act[0]));
      check("done0", 32'(done0), 32'(m_done[0]));
      check("pass0", 32'(pass0), 32'(m_pass[0]));
      check("fail0", 32'(fail0), 32'(m_fail[0]));
      check("att0", 32'(att0), 32'(m_att[0]));
      check("x1", 32'(x1), 32'(exp_x(1)));
      check("busy1", 32'(busy1), 32'(m_act[1]));
      check("done1", 32'(done1), 32'(m_done[1]));
      check("pass1", 32'(pass1), 32'(m_pass[1]));
      check("fail1", 32'(fail1), 32'(m_fail[1]));
      check("att1", 32'(att1), 32'(m_att[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_lock();
    lk_clr = 1'b1;
    step();
    lk_clr = 1'b0;
  endtask

  // Pulse start for one edge; on return the accept edge (edge 0) has just passed.
  task automatic launch(input logic [8:0] c);
    start = 1'b1;
    code  = c;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; code = '0;
    repeat (2) step();
    chk_en = 1'b1;
    check("rst_x", 32'(x0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_att", 32'(att0), 0);
    check("rst_flags", 32'({done0, pass0, fail0}), 0);
    reset = 1'b0;

    // Correct code with the lock stand-in.
    clr_lock();
    launch(LOCK_CODE);
    check("t1_x_e0", 32'(x0), 32'd3);
    check("t1_x1_e0", 32'(x1), 32'd3);
    step(); check("t1_x_e1", 32'(x0), 32'd7);
    step(); check("t1_x_e2", 32'(x0), 32'd5);
    check("t1_x1_e2", 32'(x1), 32'd3);
    step(); check("t1_x_e3", 32'(x0), 32'd0);
    check("t1_x1_e3", 32'(x1), 32'd7);
    step();
    check("t1_done", 32'(done0), 1);
    check("t1_pass", 32'(pass0), 1);
    check("t1_fail", 32'(fail0), 0);
    check("t1_att", 32'(att0), 1);
    start = 1'b1;  // coincides with done: must be refused
    step(); check("t1_start_on_done", 32'(busy0), 0);
    start = 1'b0;
    repeat (3) step();
    check("t1_x1_e8", 32'(x1), 32'd5);
    step();
    check("t1_x1_e9", 32'(x1), 32'd0);
    check("t1_busy1_e9", 32'(busy1), 1);
    repeat (50) step();

    // Wrong last symbol: every attempt times out.
    clr_lock();
    launch(9'b011_111_100);
    for (int e = 1; e <= DONE2; e++) begin
      step();
      if (e == 7) check("t2_gap_x", 32'(x0), 0);
      if (e == 9) check("t2_retry_x", 32'(x0), 32'(X9));
      if (e == DONE2 - 1) check("t2_not_done", 32'(done0), 0);
    end
    check("t2_done", 32'(done0), 1);
    check("t2_fail", 32'(fail0), 1);
    check("t2_pass", 32'(pass0), 0);
    check("t2_att", 32'(att0), 32'(MAXA));
    repeat (50) step();

    // Lock only opens on the second complete entry.
    lk_second = 1'b1;
    clr_lock();
    launch(LOCK_CODE);
    repeat (DONE3) step();
    check("t3_done", 32'(done0), 1);
    check("t3_pass", 32'(pass0), 32'(PASS3));
    check("t3_att", 32'(att0), 32'(ATT3));
    repeat (18 - DONE3) step();
    check("t3_no_third_x", 32'(x0), 0);
    check("t3_no_third_busy", 32'(busy0), 0);
    lk_second = 1'b0;
    repeat (50) step();

    // Second start with another code while sending is ignored.
    clr_lock();
    launch(LOCK_CODE);
    start = 1'b1; code = 9'b111_111_111;
    step(); check("t4_x_e1", 32'(x0), 32'd7);
    step(); check("t4_x_e2", 32'(x0), 32'd5);
    start = 1'b0;
    repeat (2) step();
    check("t4_done", 32'(done0), 1);
    check("t4_pass", 32'(pass0), 1);
    repeat (50) step();

    // Reset while waiting for y.
    ymode = 2; yr0 = 1'b0; yr1 = 1'b0;
    launch(LOCK_CODE);
    repeat (5) step();
    check("t5_in_wait", 32'(busy0), 1);
    reset = 1'b1;
    step();
    check("t5_x", 32'({x0, x1}), 0);
    check("t5_busy", 32'({busy0, busy1}), 0);
    check("t5_flags", 32'({done0, pass0, fail0, done1, pass1, fail1}), 0);
    check("t5_att", 32'({att0, att1}), 0);
    reset = 1'b0;

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) ymode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      start = ($urandom_range(0, 3) == 0);
      code  = ($urandom_range(0, 2) == 0) ? LOCK_CODE : 9'($urandom);
      yr0   = ($urandom_range(0, 5) == 0);
      yr1   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
